// File: rtl/vs_mp_iteration_controller_pkg.sv
// vs_mp_iteration_controller_pkg: shared types, FSM codes and fixed-point limits for the MP controller
package vs_mp_iteration_controller_pkg;
  localparam int SIGNAL_SIZE_DEFAULT = 4;
  localparam int DICTIONARY_SIZE_DEFAULT = 8;
  localparam int SPARSITY_LEVEL_DEFAULT = 2;
  localparam int FP_DATA_BUS_WIDTH = 32;
  localparam logic signed [FP_DATA_BUS_WIDTH-1:0] FP_SAT_MAX = {1'b0, {(FP_DATA_BUS_WIDTH-1){1'b1}}};
  localparam logic signed [FP_DATA_BUS_WIDTH-1:0] FP_SAT_MIN = {1'b1, {(FP_DATA_BUS_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {
    COMPUTE_INNER_PRODUCTS = 2'd0,
    UPDATE_RESIDUAL = 2'd1
  } vs_sensing_matrix_command_t;
  typedef logic [3:0] vs_mp_ctrl_state_t;
  localparam vs_mp_ctrl_state_t IDLE = 4'd0;
  localparam vs_mp_ctrl_state_t CLEAR_X = 4'd1;
  localparam vs_mp_ctrl_state_t COPY_Y = 4'd2;
  localparam vs_mp_ctrl_state_t CHECK = 4'd3;
  localparam vs_mp_ctrl_state_t SWEEP = 4'd4;
  localparam vs_mp_ctrl_state_t MAX_WAIT = 4'd5;
  localparam vs_mp_ctrl_state_t X_RD = 4'd6;
  localparam vs_mp_ctrl_state_t X_WAIT = 4'd7;
  localparam vs_mp_ctrl_state_t X_WR = 4'd8;
  localparam vs_mp_ctrl_state_t RES = 4'd9;
  localparam vs_mp_ctrl_state_t RES_WAIT = 4'd10;
  localparam vs_mp_ctrl_state_t FINISH = 4'd11;
endpackage

// File: rtl/vs_fp_sat_adder.sv
// vs_fp_sat_adder: combinational DW-bit signed add clamped to the representable range
module vs_fp_sat_adder #(
  parameter int DW = 32
) (
  input logic signed [DW-1:0] a,
  input logic signed [DW-1:0] b,
  output logic signed [DW-1:0] sum
);
  logic signed [DW:0] full;
  assign full = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
  assign sum = full[DW] != full[DW-1] ? (full[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : full[DW-1:0];
endmodule

// File: rtl/vs_mp_iteration_controller.sv
// vs_mp_iteration_controller: matching-pursuit run sequencer (clear x, copy y->r, K iterations); optional VS_MP_EARLY_STOP_EN
module vs_mp_iteration_controller
  import vs_mp_iteration_controller_pkg::*;
#(
  parameter int M = SIGNAL_SIZE_DEFAULT,
  parameter int N = DICTIONARY_SIZE_DEFAULT,
  parameter int K = SPARSITY_LEVEL_DEFAULT,
  parameter int DW = FP_DATA_BUS_WIDTH,
`ifdef VS_MP_EARLY_STOP_EN
  parameter logic signed [DW-1:0] THRESH = '0,
`endif
  localparam int MAW = M > 1 ? $clog2(M) : 1,
  localparam int NAW = $clog2(N),
  localparam int KW = K > 0 ? $clog2(K + 1) : 1
) (
  input logic clock,
  input logic reset_n,
  input logic start,
  input logic abort,
  output logic done,
  output logic busy,
  output logic aborted,
`ifdef VS_MP_EARLY_STOP_EN
  output logic early_stop,
`endif
  output logic [KW-1:0] iterations,
  output logic [MAW-1:0] y_read_addr,
  input logic signed [DW-1:0] y_read_data,
  output logic r_write_enable,
  output logic [MAW-1:0] r_write_addr,
  output logic signed [DW-1:0] r_write_data,
  output logic [NAW-1:0] x_read_addr,
  input logic signed [DW-1:0] x_read_data,
  output logic x_write_enable,
  output logic [NAW-1:0] x_write_addr,
  output logic signed [DW-1:0] x_write_data,
  output vs_sensing_matrix_command_t dp_command,
  output logic dp_start,
  input logic dp_done,
  output logic [NAW-1:0] dp_atom,
  output logic signed [DW-1:0] dp_coef,
  input logic [NAW-1:0] mx_location,
  input logic signed [DW-1:0] mx_value,
  input logic mx_batch_done
);
  localparam int CW = $clog2((M > N ? M : N) + 1);
  vs_mp_ctrl_state_t state, state_n, after_max;
  logic [CW-1:0] cnt, cnt_m1;
  logic [KW-1:0] iter;
  logic [NAW-1:0] loc;
  logic signed [DW-1:0] coef, cur_coef, sat_sum;
  logic got_max, take_max, have_max, stop_now, abort_q, aborted_q, abort_hit, start_hit, at_k;
  assign abort_hit = abort && state != IDLE;
  assign start_hit = start && state == IDLE;
  assign at_k = iter == KW'(K);
  assign take_max = mx_batch_done && !got_max && (state == SWEEP || state == MAX_WAIT);
  assign have_max = got_max || take_max;
  assign cur_coef = got_max ? coef : mx_value;
  assign cnt_m1 = cnt - 1'b1;
`ifdef VS_MP_EARLY_STOP_EN
  logic [DW:0] mag;
  assign mag = cur_coef[DW-1] ? -{cur_coef[DW-1], cur_coef} : {cur_coef[DW-1], cur_coef};
  assign stop_now = $signed(mag) <= $signed({THRESH[DW-1], THRESH});
`else
  assign stop_now = 1'b0;
`endif
  assign after_max = stop_now ? FINISH : X_RD;
  vs_fp_sat_adder #(.DW(DW)) u_sat (
    .a(x_read_data),
    .b(coef),
    .sum(sat_sum)
  );
  // next state: walk the run sequence; abort from any busy state drops straight to IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? CLEAR_X : IDLE;
      CLEAR_X: state_n = cnt == CW'(N - 1) ? COPY_Y : CLEAR_X;
      COPY_Y: state_n = cnt == CW'(M) ? CHECK : COPY_Y;
      CHECK: state_n = at_k ? FINISH : SWEEP;
      SWEEP: state_n = !dp_done ? SWEEP : have_max ? after_max : MAX_WAIT;
      MAX_WAIT: state_n = take_max ? after_max : MAX_WAIT;
      X_RD: state_n = X_WAIT;
      X_WAIT: state_n = X_WR;
      X_WR: state_n = RES;
      RES: state_n = RES_WAIT;
      RES_WAIT: state_n = dp_done ? CHECK : RES_WAIT;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_hit) state_n = IDLE;
  end
  // run registers: step counter, iteration count, latched max result and status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      iter <= '0;
      aborted_q <= 1'b0;
      abort_q <= 1'b0;
      got_max <= 1'b0;
      loc <= '0;
      coef <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      abort_q <= abort_hit;
      if (start_hit) begin
        iter <= '0;
        aborted_q <= 1'b0;
      end else if (abort_hit) aborted_q <= 1'b1;
      else if (state == RES_WAIT && dp_done) iter <= iter + 1'b1;
      got_max <= state == CHECK ? 1'b0 : got_max | take_max;
      if (take_max) begin
        loc <= mx_location;
        coef <= mx_value;
      end
    end
  end
`ifdef VS_MP_EARLY_STOP_EN
  // early-stop flag: raised when a weak max ends the run, dropped on the next accepted start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) early_stop <= 1'b0;
    else if (start_hit) early_stop <= 1'b0;
    else if ((state == SWEEP || state == MAX_WAIT) && state_n == FINISH) early_stop <= 1'b1;
  end
`endif
  assign busy = state != IDLE;
  assign done = (state == FINISH && !abort) || abort_q;
  assign aborted = aborted_q;
  assign iterations = iter;
  assign y_read_addr = state == COPY_Y ? cnt[MAW-1:0] : '0;
  assign r_write_enable = state == COPY_Y && cnt != '0 && !abort;
  assign r_write_addr = state == COPY_Y ? cnt_m1[MAW-1:0] : '0;
  assign r_write_data = state == COPY_Y ? y_read_data : '0;
  assign x_read_addr = loc;
  assign x_write_enable = (state == CLEAR_X || state == X_WR) && !abort;
  assign x_write_addr = state == CLEAR_X ? cnt[NAW-1:0] : loc;
  assign x_write_data = state == X_WR ? sat_sum : '0;
  assign dp_command = state == RES ? UPDATE_RESIDUAL : COMPUTE_INNER_PRODUCTS;
  assign dp_start = !abort && (state == RES || (state == CHECK && !at_k));
  assign dp_atom = loc;
  assign dp_coef = coef;
endmodule

// File: tb/tb_vs_mp_iteration_controller.sv
// tb_vs_mp_iteration_controller: table, directed and random runs checked against a plain-arithmetic MP model
module tb_vs_mp_iteration_controller;
  import vs_mp_iteration_controller_pkg::*;
  localparam int M = 4, N = 8, K = 2, DP_LAT = 5, UPD_LAT = 3;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic done, busy, aborted, early_stop;
  logic [1:0] iterations;
  logic [1:0] y_read_addr, r_write_addr;
  logic [2:0] x_read_addr, x_write_addr, dp_atom, mx_location;
  logic [31:0] y_read_data, r_write_data, x_read_data, x_write_data, dp_coef, mx_value;
  logic r_write_enable, x_write_enable, dp_start, dp_done, mx_batch_done;
  vs_sensing_matrix_command_t dp_command;
  always #5 clock = ~clock;

  vs_mp_iteration_controller #(
    .M(M), .N(N), .K(K), .DW(32)
`ifdef VS_MP_EARLY_STOP_EN
    , .THRESH(32'sh10)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .done(done), .busy(busy), .aborted(aborted),
`ifdef VS_MP_EARLY_STOP_EN
    .early_stop(early_stop),
`endif
    .iterations(iterations),
    .y_read_addr(y_read_addr), .y_read_data(y_read_data),
    .r_write_enable(r_write_enable), .r_write_addr(r_write_addr), .r_write_data(r_write_data),
    .x_read_addr(x_read_addr), .x_read_data(x_read_data),
    .x_write_enable(x_write_enable), .x_write_addr(x_write_addr), .x_write_data(x_write_data),
    .dp_command(dp_command), .dp_start(dp_start), .dp_done(dp_done),
    .dp_atom(dp_atom), .dp_coef(dp_coef),
    .mx_location(mx_location), .mx_value(mx_value), .mx_batch_done(mx_batch_done)
  );
`ifndef VS_MP_EARLY_STOP_EN
  assign early_stop = 1'b0;
`endif

  logic [31:0] ym[M], rm[M], xm[N];
  logic [2:0] prog_loc[2];
  logic [31:0] prog_coef[2];
  int prog_off = 0, run_base = 0;
  int x_wr_cnt = 0, ds_cnt = 0, done_cnt = 0, cmp_cnt = 0, dp_cnt = 0, mx_cnt = 0;
  logic mi = 1'b0;
  int total = 0, bad = 0;

  // RAMs with one-cycle read latency, dictionary processor and max identifier responders
  always @(posedge clock) begin
    dp_done <= 1'b0;
    mx_batch_done <= 1'b0;
    if (x_write_enable) begin
      xm[x_write_addr] <= x_write_data;
      x_wr_cnt <= x_wr_cnt + 1;
    end
    if (r_write_enable) rm[r_write_addr] <= r_write_data;
    y_read_data <= ym[y_read_addr];
    x_read_data <= xm[x_read_addr];
    if (done) done_cnt <= done_cnt + 1;
    if (dp_start) ds_cnt <= ds_cnt + 1;
    if (dp_cnt != 0) begin
      dp_cnt <= dp_cnt - 1;
      if (dp_cnt == 1) dp_done <= 1'b1;
    end
    if (mx_cnt != 0) begin
      mx_cnt <= mx_cnt - 1;
      if (mx_cnt == 1) begin
        mx_batch_done <= 1'b1;
        mx_location <= prog_loc[mi];
        mx_value <= prog_coef[mi];
      end
    end
    if (dp_start) begin
      if (dp_command == COMPUTE_INNER_PRODUCTS) begin
        dp_cnt <= DP_LAT;
        mx_cnt <= DP_LAT + prog_off;
        mi <= 1'(cmp_cnt - run_base);
        cmp_cnt <= cmp_cnt + 1;
      end else dp_cnt <= UPD_LAT;
    end
  end

  initial begin
    mx_location = '0;
    mx_value = '0;
    y_read_data = '0;
    x_read_data = '0;
    dp_done = 1'b0;
    mx_batch_done = 1'b0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
  endfunction

  function automatic logic [31:0] rnd_coef();
    logic [31:0] v;
    v = $urandom_range(32'h100, 32'h7FFFFFFF);
    return $urandom_range(0, 1) == 1 ? -v : v;
  endfunction

  task automatic arm(input logic [2:0] l0, input logic [31:0] c0, input logic [2:0] l1, input logic [31:0] c1, input int off);
    prog_loc[0] = l0;
    prog_coef[0] = c0;
    prog_loc[1] = l1;
    prog_coef[1] = c1;
    prog_off = off;
    run_base = cmp_cnt;
    for (int i = 0; i < M; i++) ym[i] = $urandom;
  endtask

  task automatic wait_done(input string tag, output bit seen);
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clock);
      seen = done;
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic run_mp(input string tag, input logic [2:0] l0, input logic [31:0] c0, input logic [2:0] l1, input logic [31:0] c1, input int off);
    logic [31:0] xe[N];
    int xw0, ds0, dn0;
    bit seen;
    arm(l0, c0, l1, c1, off);
    xw0 = x_wr_cnt;
    ds0 = ds_cnt;
    dn0 = done_cnt;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_iter_clr"}, iterations, 0);
    wait_done(tag, seen);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_iters"}, iterations, K);
    chk({tag, "_early"}, early_stop, 0);
    repeat (2) @(negedge clock);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_xwrites"}, x_wr_cnt - xw0, N + K);
    chk({tag, "_dpstarts"}, ds_cnt - ds0, 2 * K);
    chk({tag, "_dones"}, done_cnt - dn0, 1);
    for (int i = 0; i < N; i++) xe[i] = '0;
    xe[l0] = sat_add(xe[l0], c0);
    xe[l1] = sat_add(xe[l1], c1);
    for (int i = 0; i < N; i++) chk($sformatf("%s_x%0d", tag, i), xm[i], xe[i]);
    for (int i = 0; i < M; i++) chk($sformatf("%s_r%0d", tag, i), rm[i], ym[i]);
  endtask

  typedef struct {
    logic [2:0] l0;
    logic [31:0] c0;
    logic [2:0] l1;
    logic [31:0] c1;
    int off;
    int exp_addr;
    logic [31:0] exp_val;
  } vec_t;
  vec_t vt[5];

  initial begin
    bit seen;
    int xw0, ds0;
    vt[0] = '{3'd5, 32'h0000_8000, 3'd5, 32'h0000_4000, 0, 5, 32'h0000_C000};
    vt[1] = '{3'd5, 32'h0000_8000, 3'd5, 32'h0000_4000, 3, 5, 32'h0000_C000};
    vt[2] = '{3'd3, 32'h7FFF_FFF0, 3'd3, 32'h0000_0100, -2, 3, 32'h7FFF_FFFF};
    vt[3] = '{3'd1, 32'h8000_0010, 3'd1, 32'hFFFF_FF00, 2, 1, 32'h8000_0000};
    vt[4] = '{3'd2, 32'h0000_0011, 3'd6, 32'hFFFF_FFEF, -3, 6, 32'hFFFF_FFEF};
    repeat (2) @(negedge clock);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_iters", iterations, 0);
    chk("rst_xwe", x_write_enable, 0);
    chk("rst_rwe", r_write_enable, 0);
    chk("rst_dpstart", dp_start, 0);
    chk("rst_cmd", dp_command, COMPUTE_INNER_PRODUCTS);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_busy", busy, 0);
    for (int v = 0; v < 5; v++) begin
      run_mp($sformatf("tbl%0d", v), vt[v].l0, vt[v].c0, vt[v].l1, vt[v].c1, vt[v].off);
      chk($sformatf("tbl%0d_exp", v), xm[vt[v].exp_addr], vt[v].exp_val);
    end
    arm(3'd5, 32'h0000_8000, 3'd2, 32'h0000_9000, 0);
    xw0 = x_wr_cnt;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clock);
      seen = dp_start && dp_command == UPDATE_RESIDUAL;
    end
    chk("abort_reach_res", seen, 1);
    @(negedge clock);
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clock) abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_flag", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_iters", iterations, 0);
    chk("abort_xwrites", x_wr_cnt - xw0, N + 1);
    @(negedge clock);
    chk("abort_done_pulse", done, 0);
    chk("abort_flag_hold", aborted, 1);
    repeat (6) @(negedge clock);
    run_mp("restart", 3'd4, 32'h0000_1000, 3'd0, 32'h0000_2000, 1);
`ifdef VS_MP_EARLY_STOP_EN
    arm(3'd4, 32'h0000_0008, 3'd4, 32'h0000_0008, 1);
    xw0 = x_wr_cnt;
    ds0 = ds_cnt;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    wait_done("es", seen);
    chk("es_flag", early_stop, 1);
    chk("es_iters", iterations, 0);
    repeat (2) @(negedge clock);
    chk("es_xwrites", x_wr_cnt - xw0, N);
    chk("es_dpstarts", ds_cnt - ds0, 1);
    run_mp("es_after", 3'd7, 32'h0000_0400, 3'd7, 32'hFFFF_F000, 0);
`endif
    for (int r = 0; r < 20; r++) begin
      logic [2:0] l0, l1;
      l0 = 3'($urandom_range(0, N - 1));
      l1 = r % 3 == 0 ? l0 : 3'($urandom_range(0, N - 1));
      run_mp($sformatf("rnd%0d", r), l0, rnd_coef(), l1, rnd_coef(), int'($urandom_range(0, 7)) - 3);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
